// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict
//   Resolves RV32 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and keeps a
//   PC-indexed table of 2-bit saturating counters. The fetch stage reads
//   predictions from the table and the execute stage trains it.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   PRED_PC          fetch-stage PC used for the prediction lookup
//   PRED_TAKEN       MSB of the counter at PRED_PC's index (combinational)
//   RES_VALID        execute stage presents a conditional branch this cycle
//   RES_PC           PC of the resolving branch
//   SR1, SR2         compare operands
//   BRANCH_CCC       funct3 condition code
//   RES_PRED         prediction that fetch used for this branch
//   OUT_VALID        registered: result valid
//   BRANCH           registered: branch taken
//   MISPREDICT       registered: BRANCH differs from RES_PRED
//   ILLEGAL_CCC      registered: RES_VALID carried reserved code 010/011
//   STAT_BRANCHES    saturating count of legal resolved branches
//   STAT_MISPRED     saturating count of mispredicted branches
module branch_resolve_predict #(
  parameter int BITS        = 32,
  parameter int PC_BITS     = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_BITS-1:0]   PRED_PC,
  output logic                 PRED_TAKEN,
  input  logic                 RES_VALID,
  input  logic [PC_BITS-1:0]   RES_PC,
  input  logic [BITS-1:0]      SR1,
  input  logic [BITS-1:0]      SR2,
  input  logic [2:0]           BRANCH_CCC,
  input  logic                 RES_PRED,
  output logic                 OUT_VALID,
  output logic                 BRANCH,
  output logic                 MISPREDICT,
  output logic                 ILLEGAL_CCC,
  output logic [STAT_BITS-1:0] STAT_BRANCHES,
  output logic [STAT_BITS-1:0] STAT_MISPRED
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);

  logic [1:0]          bht_reg [BHT_ENTRIES];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          bht_cur;
  logic [1:0]          bht_next;
  logic                cond_true;
  logic                ccc_illegal;
  logic                legal_update;

  logic                 out_valid_reg;
  logic                 branch_reg;
  logic                 mispredict_reg;
  logic                 illegal_reg;
  logic [STAT_BITS-1:0] stat_branches_reg;
  logic [STAT_BITS-1:0] stat_mispred_reg;

  // Word-aligned PCs: the two low bits never select an entry, and the bits
  // above the index simply alias onto the same counter.
  assign pred_idx = PRED_PC[IDX_BITS+1:2];
  assign res_idx  = RES_PC[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PRED_PC[PC_BITS-1:IDX_BITS+2], PRED_PC[1:0],
                            RES_PC[PC_BITS-1:IDX_BITS+2], RES_PC[1:0]};

  // Prediction reads the current register contents; no bypass of a write
  // happening on the same edge.
  assign PRED_TAKEN = bht_reg[pred_idx][1];

  always_comb begin
    cond_true   = 1'b0;
    ccc_illegal = 1'b0;
    case (BRANCH_CCC)
      3'b000:  cond_true = (SR1 == SR2);
      3'b001:  cond_true = (SR1 != SR2);
      3'b100:  cond_true = ($signed(SR1) <  $signed(SR2));
      3'b101:  cond_true = ($signed(SR1) >= $signed(SR2));
      3'b110:  cond_true = (SR1 <  SR2);
      3'b111:  cond_true = (SR1 >= SR2);
      default: ccc_illegal = 1'b1;
    endcase
  end

  assign legal_update = RES_VALID & ~ccc_illegal;

  // Read-modify-write always starts from the register, so back-to-back
  // updates to one entry chain correctly.
  always_comb begin
    bht_cur  = bht_reg[res_idx];
    bht_next = bht_cur;
    if (cond_true) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= 2'b01;
    end else if (legal_update) begin
      bht_reg[res_idx] <= bht_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg     <= 1'b0;
      branch_reg        <= 1'b0;
      mispredict_reg    <= 1'b0;
      illegal_reg       <= 1'b0;
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else begin
      out_valid_reg  <= RES_VALID;
      branch_reg     <= legal_update & cond_true;
      mispredict_reg <= legal_update & (cond_true != RES_PRED);
      illegal_reg    <= RES_VALID & ccc_illegal;
      if (legal_update && stat_branches_reg != '1)
        stat_branches_reg <= stat_branches_reg + 1'b1;
      if (legal_update && (cond_true != RES_PRED) && stat_mispred_reg != '1)
        stat_mispred_reg <= stat_mispred_reg + 1'b1;
    end
  end

  assign OUT_VALID     = out_valid_reg;
  assign BRANCH        = branch_reg;
  assign MISPREDICT    = mispredict_reg;
  assign ILLEGAL_CCC   = illegal_reg;
  assign STAT_BRANCHES = stat_branches_reg;
  assign STAT_MISPRED  = stat_mispred_reg;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Testbench for branch_resolve_predict: directed scenarios plus randomized
// traffic checked against a behavioural model (counter array + counts).
module tb_branch_resolve_predict;

  localparam int ENTRIES  = 16;
  localparam int STATB    = 4;
  localparam int STAT_MAX = (1 << STATB) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pred_pc = '0;
  logic             pred_taken;
  logic             res_valid = 1'b0;
  logic [31:0]      res_pc = '0;
  logic [31:0]      sr1 = '0;
  logic [31:0]      sr2 = '0;
  logic [2:0]       ccc = '0;
  logic             res_pred = 1'b0;
  logic             out_valid;
  logic             branch;
  logic             mispredict;
  logic             illegal_ccc;
  logic [STATB-1:0] stat_branches;
  logic [STATB-1:0] stat_mispred;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_ctr [ENTRIES];
  int m_branches;
  int m_mispred;

  branch_resolve_predict #(
    .BITS(32), .PC_BITS(32), .BHT_ENTRIES(ENTRIES), .STAT_BITS(STATB)
  ) dut (
    .clk(clk), .rst(rst),
    .PRED_PC(pred_pc), .PRED_TAKEN(pred_taken),
    .RES_VALID(res_valid), .RES_PC(res_pc),
    .SR1(sr1), .SR2(sr2), .BRANCH_CCC(ccc), .RES_PRED(res_pred),
    .OUT_VALID(out_valid), .BRANCH(branch), .MISPREDICT(mispredict),
    .ILLEGAL_CCC(illegal_ccc),
    .STAT_BRANCHES(stat_branches), .STAT_MISPRED(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int entry_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint ua, ub;
    sa = int'(a);
    sb = int'(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (c)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_branches = 0;
    m_mispred  = 0;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_branch"}, 32'(branch), 0);
    check({tag, "_stat_br"}, 32'(stat_branches), 0);
    check({tag, "_stat_mp"}, 32'(stat_mispred), 0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    res_valid = 1'b0;
    #1;
    check_cleared(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, check prediction before the edge, then
  // check the registered result at the following negedge.
  task automatic do_cycle(input logic v, input logic [31:0] rpc, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] c, input logic p,
                          input logic [31:0] ppc);
    bit legal, tk, mp;
    int e;
    res_valid = v; res_pc = rpc; sr1 = a; sr2 = b; ccc = c; res_pred = p; pred_pc = ppc;
    #1;
    check("pred_taken", 32'(pred_taken), 32'(m_ctr[entry_of(ppc)] >= 2));
    legal = v && (c != 3'd2) && (c != 3'd3);
    tk    = legal && ref_taken(c, a, b);
    mp    = legal && (tk != p);
    if (legal) begin
      e = entry_of(rpc);
      m_ctr[e] = tk ? ((m_ctr[e] < 3) ? m_ctr[e] + 1 : 3) : ((m_ctr[e] > 0) ? m_ctr[e] - 1 : 0);
      if (m_branches < STAT_MAX) m_branches++;
      if (mp && m_mispred < STAT_MAX) m_mispred++;
    end
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    $display("txn v=%0b pc=%h a=%h b=%h ccc=%0d pred=%0b -> valid=%0b br=%0b mp=%0b ill=%0b stats=%0d/%0d",
             v, rpc, a, b, c, p, out_valid, branch, mispredict, illegal_ccc, stat_branches, stat_mispred);
    check("out_valid", 32'(out_valid), 32'(v));
    check("branch", 32'(branch), 32'(tk));
    check("mispredict", 32'(mispredict), 32'(mp));
    check("illegal_ccc", 32'(illegal_ccc), 32'(v && !legal));
    check("stat_branches", 32'(stat_branches), 32'(m_branches));
    check("stat_mispred", 32'(stat_mispred), 32'(m_mispred));
  endtask

  initial begin
    model_reset();
    // Reset state
    pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_taken", 32'(pred_taken), 0);
    check_cleared("rst");
    @(negedge clk);
    rst = 1'b0;

    // Signed vs unsigned compares
    do_cycle(1, 32'h200, 32'hFFFFFFFF, 32'h1, 3'd4, 0, 32'h0);
    check("blt_neg1_lt_1", 32'(branch), 1);
    do_cycle(1, 32'h204, 32'hFFFFFFFF, 32'h1, 3'd6, 0, 32'h0);
    check("bltu_max_lt_1", 32'(branch), 0);
    do_cycle(1, 32'h208, 32'hFFFFFFFF, 32'h1, 3'd7, 0, 32'h0);
    check("bgeu_max_ge_1", 32'(branch), 1);
    do_cycle(1, 32'h20C, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'd0, 0, 32'h0);
    check("beq_equal", 32'(branch), 1);

    // Training at 0x40, lookup at the same PC each cycle (no bypass)
    apply_reset("rst2");
    for (int k = 0; k < 3; k++) begin
      do_cycle(1, 32'h40, 32'h7, 32'h7, 3'd0, 0, 32'h40);
      check("train_mispredict", 32'(mispredict), 1);
    end
    pred_pc = 32'h40;
    #1;
    check("trained_pred", 32'(pred_taken), 1);
    check("train_stat_mp", 32'(stat_mispred), 3);
    pred_pc = 32'h40 + 4 * ENTRIES;
    #1;
    check("alias_pred", 32'(pred_taken), 1);

    // Reserved code leaves table and counts untouched
    do_cycle(1, 32'h44, 32'h1, 32'h1, 3'd2, 0, 32'h44);
    do_cycle(1, 32'h44, 32'h1, 32'h2, 3'd3, 1, 32'h44);
    do_cycle(0, 32'h44, 32'h1, 32'h1, 3'd0, 0, 32'h44);

    // Saturation of 4-bit stats, then asynchronous reset mid-run
    apply_reset("rst3");
    for (int k = 0; k < 20; k++)
      do_cycle(1, 32'(k * 4), 32'h3, 32'h3, 3'd0, 0, 32'(k * 4));
    check("sat_branches", 32'(stat_branches), STAT_MAX);
    check("sat_mispred", 32'(stat_mispred), STAT_MAX);
    res_valid = 1'b1;
    apply_reset("rst_mid");
    pred_pc = 32'h0;
    #1;
    check("post_rst_pred", 32'(pred_taken), 0);

    // Randomized traffic in blocks separated by resets
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a, b, rpc, ppc;
        logic [2:0]  c;
        logic        v, p;
        v   = ($urandom_range(0, 3) != 0);
        rpc = 32'($urandom_range(0, 63)) << 2 | 32'($urandom_range(0, 3));
        ppc = ($urandom_range(0, 1) == 0) ? rpc : (32'($urandom_range(0, 63)) << 2);
        c   = 3'($urandom_range(0, 7));
        a   = $urandom;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = 32'($urandom_range(0, 3));
          2:       b = ~a;
          default: b = $urandom;
        endcase
        p = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1))
                                        : 1'(m_ctr[entry_of(rpc)] >= 2);
        do_cycle(v, rpc, a, b, c, p, ppc);
      end
      apply_reset("rst_blk");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
